// File: rtl/dmac_desc_fifo_if.sv
// Push/pop/status bundle between the descriptor writer, the descriptor FIFO and the DMAC master.
// The FIFO takes the slave modport; the side driving pushes, pops and clear takes master.
interface dmac_desc_fifo_if #(
    parameter int AW = 2
);
    logic          clear;
    logic          wr_en;
    logic [31:0]   din_src;
    logic [31:0]   din_dest;
    logic [31:0]   din_size;
    logic          rd_en;
    logic          rd_ack;
    logic          rd_err;
    logic          wr_err;
    logic [31:0]   dout_src;
    logic [31:0]   dout_dest;
    logic [31:0]   dout_size;
    logic          full;
    logic          empty;
    logic [AW:0]   data_count;

    modport slave (
        input  clear, wr_en, din_src, din_dest, din_size, rd_en,
        output rd_ack, rd_err, wr_err, dout_src, dout_dest, dout_size,
               full, empty, data_count
    );

    modport master (
        output clear, wr_en, din_src, din_dest, din_size, rd_en,
        input  rd_ack, rd_err, wr_err, dout_src, dout_dest, dout_size,
               full, empty, data_count
    );
endinterface

// File: rtl/dmac_desc_fifo.sv
// Descriptor FIFO feeding the DMAC master: {src, dest, size} entries, registered pop
// data with one-cycle ack/error pulses, overflow reported on wr_err.
module dmac_desc_fifo #(
    parameter int AW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dmac_desc_fifo_if.slave       bus
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] size;
    } desc_t;

    desc_t          mem_q [DEPTH];
    desc_t          mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    desc_t          dout_q, dout_d;
    logic           rd_ack_q, rd_ack_d;
    logic           rd_err_q, rd_err_d;
    logic           wr_err_q, wr_err_d;

    logic           full_w, empty_w;
    logic           push_ok, pop_ok;

    // Push and pop are both judged against the pre-edge count, so a push into an
    // empty FIFO is never visible to a pop in the same cycle.
    always_comb begin
        full_w   = (count_q == FULL_CNT);
        empty_w  = (count_q == '0);
        push_ok  = bus.wr_en & ~full_w  & ~bus.clear;
        pop_ok   = bus.rd_en & ~empty_w & ~bus.clear;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        rd_ack_d = pop_ok;
        rd_err_d = bus.rd_en & empty_w & ~bus.clear;
        wr_err_d = bus.wr_en & full_w  & ~bus.clear;

        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = '{src: bus.din_src, dest: bus.din_dest, size: bus.din_size};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                dout_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.dout_src   = dout_q.src;
    assign bus.dout_dest  = dout_q.dest;
    assign bus.dout_size  = dout_q.size;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.data_count = count_q;

    a_ack_err_excl: assert property (@(posedge clk) disable iff (reset) !(rd_ack_q && rd_err_q));
    a_count_range:  assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);
endmodule
